// File: rtl/gate_truth_table_checker.sv
// Stimulus-and-capture engine for a two-input gate: sweeps {a,b} through 00..11,
// samples y after a settle window per vector and compares the table with EXPECTED.
module gate_truth_table_checker #(
    parameter logic [3:0] EXPECTED = 4'b1000,
    parameter int         SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] table_out,
    output logic [3:0] mismatch_mask
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t     r_state, w_state;
    logic [1:0] r_idx,   w_idx;
    logic [7:0] r_cnt,   w_cnt;
    logic [1:0] r_ab,    w_ab;
    logic       r_busy,  w_busy;
    logic       r_done,  w_done;
    logic       r_pass,  w_pass;
    logic [3:0] r_table, w_table;
    logic [3:0] r_mask,  w_mask;

    // Every output is registered, so next values for all of them are formed here.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_ab    = 2'b00;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_table = r_table;
        w_mask  = r_mask;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_DRIVE;
                    w_idx   = 2'd0;
                    w_cnt   = 8'd0;
                    w_busy  = 1'b1;
                    w_pass  = 1'b0;
                    w_table = 4'b0000;
                    w_mask  = 4'b0000;
                end
            end
            S_DRIVE: begin
                w_ab   = r_ab;
                w_busy = 1'b1;
                w_cnt  = r_cnt + 8'd1;
                if (r_cnt == SETTLE_CNT) begin
                    w_table[r_idx] = y;
                    w_cnt          = 8'd0;
                    if (r_idx == 2'd3) begin
                        // Verdict uses the table including the bit captured on this edge.
                        w_state = S_DONE;
                        w_idx   = 2'd0;
                        w_ab    = 2'b00;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_mask  = w_table ^ EXPECTED;
                        w_pass  = (w_table == EXPECTED);
                    end else begin
                        w_idx = r_idx + 2'd1;
                        w_ab  = r_idx + 2'd1;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= 8'd0;
            r_ab    <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= 4'b0000;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_ab    <= w_ab;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_table <= w_table;
            r_mask  <= w_mask;
        end
    end

    assign a             = r_ab[1];
    assign b             = r_ab[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign table_out     = r_table;
    assign mismatch_mask = r_mask;

endmodule
